// File: rtl/oto_pilot_pkg.sv
// Shared types and widths for the altitude-hold controller.
package oto_pilot_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned ALT_W_DEF = 10;
    localparam int unsigned TGT_W_DEF = 7;

    // Encoding is visible on state_o, so values are pinned explicitly.
    typedef enum logic [STATE_W-1:0] {
        StIdle  = 3'd0,
        StClimb = 3'd1,
        StHold  = 3'd2,
        StOver  = 3'd3,
        StFault = 3'd4
    } state_t;

endpackage

// File: rtl/sensor_watchdog.sv
// Saturating cycle counter that flags a missing-sensor condition.
module sensor_watchdog #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles since the last clear, holding at CNT_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Not gated by clr: expiry takes precedence over a same-cycle sample.
    assign expired = run && (r_cnt == CNT_MAX);

endmodule

// File: rtl/altitude_hold_ctrl.sv
// Closed-loop altitude hold: source mux, sample register, hysteresis compare and FSM.
module altitude_hold_ctrl
    import oto_pilot_pkg::*;
#(
    parameter int unsigned ALT_W     = ALT_W_DEF,
    parameter int unsigned TGT_W     = TGT_W_DEF,
    parameter int unsigned TGT_SHIFT = 3,
    parameter int unsigned HYST      = 4,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               src_sel_i,
    input  logic [ALT_W-1:0]   alt_i,
    input  logic               alt_vld_i,
    input  logic [ALT_W-1:0]   gnss_i,
    input  logic               gnss_vld_i,
    input  logic [TGT_W-1:0]   tgt_i,
    output logic               motor_o,
    output logic               green_o,
    output logic               red_o,
    output logic [STATE_W-1:0] state_o
);

    // One extra bit so T + HYST never wraps.
    localparam int unsigned AW = ALT_W + 1;

    logic             w_sel_vld;
    logic [ALT_W-1:0] w_sel_dat;
    logic             w_src_chg;
    logic             w_wd_clr;
    logic             w_expired;
    logic             w_eval;
    logic [AW-1:0]    w_t;
    logic [AW-1:0]    w_lo;
    logic [AW-1:0]    w_hi;
    logic [AW-1:0]    w_alt;
    logic             w_below;
    logic             w_above;
    logic             w_at_tgt;
    state_t           w_state_d;

    logic [ALT_W-1:0] r_smp;
    logic             r_have_smp;
    logic             r_new;
    logic             r_src_sel;
    state_t           r_state;
    logic             r_motor;
    logic             r_green;
    logic             r_red;

    assign w_sel_vld = src_sel_i ? gnss_vld_i : alt_vld_i;
    assign w_sel_dat = src_sel_i ? gnss_i : alt_i;
    assign w_src_chg = (src_sel_i != r_src_sel);

    // Capture the selected source; a source switch invalidates the held sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp      <= '0;
            r_have_smp <= 1'b0;
            r_new      <= 1'b0;
            r_src_sel  <= 1'b0;
        end else begin
            r_src_sel <= src_sel_i;
            r_new     <= w_sel_vld;
            if (w_sel_vld) begin
                r_smp      <= w_sel_dat;
                r_have_smp <= 1'b1;
            end else if (w_src_chg) begin
                r_have_smp <= 1'b0;
            end
        end
    end

    assign w_wd_clr = w_sel_vld || w_src_chg || !en_i;

    sensor_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wd_clr),
        .run     (en_i),
        .expired (w_expired)
    );

    assign w_t      = AW'(tgt_i) << TGT_SHIFT;
    assign w_hi     = w_t + AW'(HYST);
    assign w_lo     = (w_t >= AW'(HYST)) ? (w_t - AW'(HYST)) : '0;
    assign w_alt    = {1'b0, r_smp};
    assign w_below  = (w_alt < w_lo);
    assign w_above  = (w_alt > w_hi);
    assign w_at_tgt = (w_alt >= w_t);
    assign w_eval   = r_new && r_have_smp;

    // Next-state: disable, then watchdog expiry, then per-sample evaluation.
    always_comb begin
        w_state_d = r_state;
        if (!en_i) begin
            w_state_d = StIdle;
        end else if (w_expired && (r_state != StIdle)) begin
            w_state_d = StFault;
        end else if (w_eval) begin
            unique case (r_state)
                StIdle, StFault: begin
                    if (w_below) begin
                        w_state_d = StClimb;
                    end else if (w_above) begin
                        w_state_d = StOver;
                    end else begin
                        w_state_d = StHold;
                    end
                end
                StClimb: begin
                    // Climb all the way to T, not just into the band.
                    if (w_above) begin
                        w_state_d = StOver;
                    end else if (w_at_tgt) begin
                        w_state_d = StHold;
                    end
                end
                StHold: begin
                    if (w_below) begin
                        w_state_d = StClimb;
                    end else if (w_above) begin
                        w_state_d = StOver;
                    end
                end
                StOver: begin
                    if (w_below) begin
                        w_state_d = StClimb;
                    end else if (!w_above) begin
                        w_state_d = StHold;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // State and decoded outputs registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_motor <= 1'b0;
            r_green <= 1'b0;
            r_red   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_motor <= (w_state_d == StClimb);
            r_green <= (w_state_d == StHold);
            r_red   <= (w_state_d == StOver) || (w_state_d == StFault);
        end
    end

    assign motor_o = r_motor;
    assign green_o = r_green;
    assign red_o   = r_red;
    assign state_o = r_state;

endmodule

// File: tb/tb_altitude_hold_ctrl.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic against a reference model.
module tb_altitude_hold_ctrl;

    localparam int unsigned ALT_W     = 10;
    localparam int unsigned TGT_W     = 7;
    localparam int unsigned TGT_SHIFT = 3;
    localparam int unsigned HYST      = 4;
    localparam int unsigned TIMEOUT   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic             src_sel_i;
    logic [ALT_W-1:0] alt_i;
    logic             alt_vld_i;
    logic [ALT_W-1:0] gnss_i;
    logic             gnss_vld_i;
    logic [TGT_W-1:0] tgt_i;
    logic             motor_o;
    logic             green_o;
    logic             red_o;
    logic [2:0]       state_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state as plain ints, watchdog as a timestamp of the last clear.
    int m_state    = 0;
    int m_smp      = 0;
    bit m_pend     = 1'b0;
    bit m_prev_sel = 1'b0;
    int m_cyc      = 0;
    int m_last_clr = 0;

    always #5 clk = ~clk;

    altitude_hold_ctrl #(
        .ALT_W     (ALT_W),
        .TGT_W     (TGT_W),
        .TGT_SHIFT (TGT_SHIFT),
        .HYST      (HYST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .src_sel_i  (src_sel_i),
        .alt_i      (alt_i),
        .alt_vld_i  (alt_vld_i),
        .gnss_i     (gnss_i),
        .gnss_vld_i (gnss_vld_i),
        .tgt_i      (tgt_i),
        .motor_o    (motor_o),
        .green_o    (green_o),
        .red_o      (red_o),
        .state_o    (state_o)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Decision for a fresh sample given the state it is judged from.
    function automatic int judge(input int st, input int a, input int tgt);
        int t;
        int lo;
        int hi;
        t  = tgt * (1 << TGT_SHIFT);
        lo = (t >= int'(HYST)) ? t - int'(HYST) : 0;
        hi = t + int'(HYST);
        case (st)
            1:       return (a > hi) ? 3 : ((a >= t) ? 2 : 1);
            2:       return (a < lo) ? 1 : ((a > hi) ? 3 : 2);
            3:       return (a < lo) ? 1 : ((a <= hi) ? 2 : 3);
            default: return (a < lo) ? 1 : ((a > hi) ? 3 : 2);
        endcase
    endfunction

    task automatic model_edge();
        int  nxt;
        bit  expired;
        bit  sv;
        int  sd;
        m_cyc++;
        if (rst) begin
            m_state    = 0;
            m_smp      = 0;
            m_pend     = 1'b0;
            m_prev_sel = 1'b0;
            m_last_clr = m_cyc;
        end else begin
            expired = en_i && ((m_cyc - m_last_clr) >= int'(TIMEOUT));
            nxt = m_state;
            if (!en_i)                         nxt = 0;
            else if (expired && m_state != 0)  nxt = 4;
            else if (m_pend)                   nxt = judge(m_state, m_smp, int'(tgt_i));
            sv = src_sel_i ? gnss_vld_i : alt_vld_i;
            sd = src_sel_i ? int'(gnss_i) : int'(alt_i);
            m_pend = sv;
            if (sv) begin
                m_smp      = sd;
                m_last_clr = m_cyc;
            end
            if (src_sel_i != m_prev_sel || !en_i) m_last_clr = m_cyc;
            m_prev_sel = src_sel_i;
            m_state    = nxt;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("state", int'(state_o), m_state);
        check_eq("motor", int'(motor_o), int'(m_state == 1));
        check_eq("green", int'(green_o), int'(m_state == 2));
        check_eq("red",   int'(red_o),   int'(m_state == 3 || m_state == 4));
    endtask

    // Valid edge, then the evaluation edge.
    task automatic send_alt(input int a);
        alt_i     = ALT_W'(a);
        alt_vld_i = 1'b1;
        step();
        alt_vld_i = 1'b0;
        step();
    endtask

    initial begin
        int vld_pct;
        int t;
        int a;
        rst = 1'b1; en_i = 1'b0; src_sel_i = 1'b0;
        alt_i = '0; alt_vld_i = 1'b0; gnss_i = '0; gnss_vld_i = 1'b0; tgt_i = '0;
        @(negedge clk);

        // Reset held with valids toggling
        for (int i = 0; i < 2; i++) begin
            alt_vld_i = ~alt_vld_i; gnss_vld_i = ~gnss_vld_i; alt_i = 10'd100;
            step();
            check_eq("rst_state", int'(state_o), 0);
            check_eq("rst_outs", int'({motor_o, green_o, red_o}), 0);
        end
        rst = 1'b0; alt_vld_i = 1'b0; gnss_vld_i = 1'b0;
        step();
        check_eq("post_rst_state", int'(state_o), 0);
        check_eq("post_rst_outs", int'({motor_o, green_o, red_o}), 0);

        // Climb then hold, T=400
        en_i = 1'b1; tgt_i = 7'd50;
        alt_i = 10'd100; alt_vld_i = 1'b1;
        step();
        check_eq("climb_latency", int'(state_o), 0);
        alt_vld_i = 1'b0;
        step();
        check_eq("climb_motor", int'(motor_o), 1);
        send_alt(398);
        check_eq("climb_398", int'(state_o), 1);
        send_alt(400);
        check_eq("hold_400", int'(state_o), 2);
        check_eq("hold_green", int'(green_o), 1);
        check_eq("hold_motor", int'(motor_o), 0);

        // Hysteresis and overshoot
        send_alt(397);
        check_eq("hyst_397", int'(state_o), 2);
        send_alt(395);
        check_eq("hyst_395", int'(state_o), 1);
        send_alt(405);
        check_eq("over_405", int'(state_o), 3);
        check_eq("over_red", int'(red_o), 1);
        send_alt(404);
        check_eq("back_404", int'(state_o), 2);

        // Timeout: 16 edges without a valid since the last one
        for (int i = 0; i < 14; i++) begin
            step();
            check_eq("wd_pre", int'(state_o), 2);
        end
        step();
        check_eq("wd_fault", int'(state_o), 4);
        check_eq("wd_red", int'(red_o), 1);
        send_alt(400);
        check_eq("fault_recover", int'(state_o), 2);

        // Source switch
        en_i = 1'b0;
        step();
        en_i = 1'b1; gnss_i = 10'd100; gnss_vld_i = 1'b1;
        step();
        gnss_vld_i = 1'b0;
        step();
        check_eq("gnss_ignored", int'(state_o), 0);
        src_sel_i = 1'b1;
        step();
        gnss_vld_i = 1'b1;
        step();
        gnss_vld_i = 1'b0;
        step();
        check_eq("gnss_climb", int'(state_o), 1);

        // tgt=0, alt=0: lo saturates, so hold rather than climb
        src_sel_i = 1'b0;
        step();
        en_i = 1'b0;
        step();
        en_i = 1'b1; tgt_i = 7'd0;
        send_alt(0);
        check_eq("tgt0_hold", int'(state_o), 2);

        // Enable dropped while climbing
        tgt_i = 7'd50;
        send_alt(100);
        check_eq("pre_en_drop", int'(state_o), 1);
        en_i = 1'b0;
        step();
        check_eq("en_drop_state", int'(state_o), 0);
        check_eq("en_drop_motor", int'(motor_o), 0);

        // Valid on the expiry cycle: fault wins, sample evaluated next
        en_i = 1'b1;
        send_alt(400);
        check_eq("same_pre", int'(state_o), 2);
        for (int i = 0; i < 14; i++) step();
        alt_vld_i = 1'b1;
        step();
        check_eq("same_fault", int'(state_o), 4);
        alt_vld_i = 1'b0;
        step();
        check_eq("same_after", int'(state_o), 2);

        // Randomized traffic
        vld_pct = 30;
        t = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       vld_pct = 0;
                    1:       vld_pct = 5;
                    default: vld_pct = 40;
                endcase
            end
            if ($urandom_range(0, 39) == 0) t = $urandom_range(0, 127);
            rst        = ($urandom_range(0, 299) == 0);
            en_i       = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 99) == 0) src_sel_i = ~src_sel_i;
            tgt_i      = TGT_W'(t);
            a          = t * 8 + $urandom_range(0, 24) - 12;
            if (a < 0) a = 0;
            if (a > 1023) a = 1023;
            alt_i      = ALT_W'(a);
            gnss_i     = ALT_W'($urandom_range(0, 1023));
            alt_vld_i  = ($urandom_range(0, 99) < vld_pct);
            gnss_vld_i = ($urandom_range(0, 99) < vld_pct);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
